// File: rtl/control_unit_if.sv
// Datapath <-> control unit bundle: instruction/flags/MFC in, every datapath control out.
// master = control unit side, slave = datapath side.
interface control_unit_if;
    logic [31:0] IR_Out;
    logic [3:0]  Flags;
    logic        MFC;

    logic MFA, RW_RAM, SALU, RF_CLR, RF_RW, SSAB, SSOP, SMA, STA;
    logic MAR_EN, SR_EN, SE_EN, MDR_EN, SHT_EN, IR_EN, SGN_EN;
    logic [1:0] DataSize, WRA, SRA, SRB, SISE, SALUB;
    logic [3:0] ALUA;
    logic [4:0] STATE;
    logic       FAULT;

    modport master (
        input  IR_Out, Flags, MFC,
        output MFA, RW_RAM, SALU, RF_CLR, RF_RW, SSAB, SSOP, SMA, STA,
               MAR_EN, SR_EN, SE_EN, MDR_EN, SHT_EN, IR_EN, SGN_EN,
               DataSize, WRA, SRA, SRB, SISE, SALUB, ALUA, STATE, FAULT
    );

    modport slave (
        output IR_Out, Flags, MFC,
        input  MFA, RW_RAM, SALU, RF_CLR, RF_RW, SSAB, SSOP, SMA, STA,
               MAR_EN, SR_EN, SE_EN, MDR_EN, SHT_EN, IR_EN, SGN_EN,
               DataSize, WRA, SRA, SRB, SISE, SALUB, ALUA, STATE, FAULT
    );
endinterface

// File: rtl/control_unit.sv
// Moore FSM sequencing the multi-cycle ARM datapath (fetch/decode/cond/execute)
// with a memory-wait watchdog that traps to HALT when MFC never arrives.
module control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          CLR,
    control_unit_if.master bus
);
    typedef enum logic [4:0] {
        S_RESET  = 5'd0,  S_FETCH1 = 5'd1,  S_FETCH2 = 5'd2,  S_FETCH3 = 5'd3,
        S_FETCH4 = 5'd4,  S_DECODE = 5'd5,  S_DP     = 5'd6,  S_MEM1   = 5'd7,
        S_LD1    = 5'd8,  S_LD2    = 5'd9,  S_ST1    = 5'd10, S_ST2    = 5'd11,
        S_BL1    = 5'd12, S_BR1    = 5'd13, S_HALT   = 5'd31
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    state_t      state, dec_next, wait_next;
    logic [7:0]  wdog;
    logic        fault;
    logic        wd_expire;
    logic [31:0] ir;
    logic        unused_ir;

    assign ir        = bus.IR_Out;
    assign unused_ir = ^{ir[21], ir[19:0]};
    assign wd_expire = (wdog == 8'(MEM_TIMEOUT - 1));

    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_comb begin
        dec_next = S_FETCH1;
        if (!cond_pass(ir[31:28], bus.Flags))  dec_next = S_FETCH1;
        else if (ir[27:26] == 2'b00)           dec_next = S_DP;
        else if (ir[27:25] == 3'b010)          dec_next = S_MEM1;
        else if (ir[27:25] == 3'b101)          dec_next = ir[24] ? S_BL1 : S_BR1;
    end

    always_comb begin
        case (state)
            S_FETCH3: wait_next = S_FETCH4;
            S_LD1:    wait_next = S_LD2;
            default:  wait_next = S_FETCH1;
        endcase
    end

    // Watchdog is zeroed in every non-wait state, which covers both entry and exit.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_RESET;
            fault <= 1'b0;
            wdog  <= '0;
        end else begin
            wdog <= '0;
            case (state)
                S_RESET:  state <= S_FETCH1;
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: state <= S_FETCH3;
                S_FETCH3, S_LD1, S_ST2: begin
                    if (bus.MFC) begin
                        state <= wait_next;
                    end else if (wd_expire) begin
                        state <= S_HALT;
                        fault <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                S_FETCH4: state <= S_DECODE;
                S_DECODE: state <= dec_next;
                S_DP:     state <= S_FETCH1;
                S_MEM1:   state <= ir[20] ? S_LD1 : S_ST1;
                S_LD2:    state <= S_FETCH1;
                S_ST1:    state <= S_ST2;
                S_BL1:    state <= S_BR1;
                S_BR1:    state <= S_FETCH1;
                S_HALT:   state <= S_HALT;
                default:  state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        bus.MFA = 1'b0;    bus.RW_RAM = 1'b0; bus.SALU = 1'b0;   bus.RF_CLR = 1'b0;
        bus.RF_RW = 1'b0;  bus.SSAB = 1'b0;   bus.SSOP = 1'b0;   bus.SMA = 1'b0;
        bus.STA = 1'b0;    bus.MAR_EN = 1'b0; bus.SR_EN = 1'b0;  bus.SE_EN = 1'b0;
        bus.MDR_EN = 1'b0; bus.SHT_EN = 1'b0; bus.IR_EN = 1'b0;  bus.SGN_EN = 1'b0;
        bus.DataSize = 2'b00; bus.WRA = 2'd0; bus.SRA = 2'd0;    bus.SRB = 2'd0;
        bus.SISE = 2'd0;   bus.SALUB = 2'd0;  bus.ALUA = 4'b0000;
        bus.STATE = state;
        bus.FAULT = fault;
        case (state)
            S_RESET:  bus.RF_CLR = 1'b1;
            S_FETCH1: begin
                bus.SRB = 2'd1; bus.SSOP = 1'b1; bus.SALUB = 2'd3;
                bus.ALUA = ALU_MOV; bus.MAR_EN = 1'b1;
            end
            S_FETCH2: begin
                bus.SRA = 2'd1; bus.SALUB = 2'd1; bus.ALUA = ALU_ADD; bus.WRA = 2'd1;
                bus.RF_RW = 1'b1; bus.MFA = 1'b1; bus.RW_RAM = 1'b1; bus.DataSize = 2'b10;
            end
            S_FETCH3: begin
                bus.MFA = 1'b1; bus.RW_RAM = 1'b1; bus.DataSize = 2'b10;
                bus.SMA = 1'b1; bus.MDR_EN = 1'b1;
            end
            S_FETCH4: bus.IR_EN = 1'b1;
            S_DP: begin
                bus.SALU = 1'b1; bus.SALUB = 2'd3; bus.SHT_EN = 1'b1;
                bus.SR_EN = ir[20];
                bus.RF_RW = (ir[24:23] != 2'b10);   // TST/TEQ/CMP/CMN only set flags
                if (ir[25]) begin
                    bus.SE_EN = 1'b1;
                end else begin
                    bus.SSOP = 1'b1; bus.SRB = 2'd3; bus.SSAB = 1'b1;
                end
            end
            S_MEM1: begin
                bus.SE_EN = 1'b1; bus.SISE = 2'd1; bus.SALUB = 2'd3; bus.MAR_EN = 1'b1;
                bus.ALUA = ir[23] ? ALU_ADD : ALU_SUB;
            end
            S_LD1: begin
                bus.MFA = 1'b1; bus.RW_RAM = 1'b1; bus.SMA = 1'b1; bus.MDR_EN = 1'b1;
                bus.DataSize = ir[22] ? 2'b00 : 2'b10;
            end
            S_LD2: begin
                bus.ALUA = ALU_MOV; bus.RF_RW = 1'b1;
            end
            S_ST1: begin
                bus.SRB = 2'd2; bus.SSOP = 1'b1; bus.SALUB = 2'd3;
                bus.ALUA = ALU_MOV; bus.MDR_EN = 1'b1;
            end
            S_ST2: begin
                bus.MFA = 1'b1; bus.DataSize = ir[22] ? 2'b00 : 2'b10;
            end
            S_BL1: begin
                bus.SRB = 2'd1; bus.SSOP = 1'b1; bus.SALUB = 2'd3;
                bus.ALUA = ALU_MOV; bus.WRA = 2'd2; bus.RF_RW = 1'b1;
            end
            S_BR1: begin
                bus.SRA = 2'd1; bus.SALUB = 2'd2; bus.ALUA = ALU_ADD;
                bus.WRA = 2'd1; bus.RF_RW = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per instruction, a queue of expected states (with the MFC
// to drive each cycle) is built from the sequencing rules and every cycle is checked.
module tb_control_unit;
    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic mfa, rw_ram, salu, rf_clr, rf_rw, ssab, ssop, sma, sta;
        logic mar_en, sr_en, se_en, mdr_en, sht_en, ir_en, sgn_en;
        logic [1:0] ds, wra, sra, srb, sise, salub;
        logic [3:0] alua;
        logic fault;
    } ctl_t;

    typedef struct {
        int st;
        bit mfc;
    } step_t;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    int   checks = 0;
    int   errors = 0;
    step_t q[$];
    ctl_t got;

    control_unit_if bus ();

    control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    assign got = {bus.MFA, bus.RW_RAM, bus.SALU, bus.RF_CLR, bus.RF_RW, bus.SSAB, bus.SSOP,
                  bus.SMA, bus.STA, bus.MAR_EN, bus.SR_EN, bus.SE_EN, bus.MDR_EN, bus.SHT_EN,
                  bus.IR_EN, bus.SGN_EN, bus.DataSize, bus.WRA, bus.SRA, bus.SRB, bus.SISE,
                  bus.SALUB, bus.ALUA, bus.FAULT};

    // Control outputs each state must show, straight from the state table.
    function automatic ctl_t exp_ctl(int st, logic [31:0] ir);
        ctl_t c;
        c = '0;
        case (st)
            0:  c.rf_clr = 1;
            1:  begin c.srb = 1; c.ssop = 1; c.salub = 3; c.alua = 4'b1101; c.mar_en = 1; end
            2:  begin c.sra = 1; c.salub = 1; c.alua = 4'b0100; c.wra = 1; c.rf_rw = 1;
                      c.mfa = 1; c.rw_ram = 1; c.ds = 2'b10; end
            3:  begin c.mfa = 1; c.rw_ram = 1; c.ds = 2'b10; c.sma = 1; c.mdr_en = 1; end
            4:  c.ir_en = 1;
            6:  begin
                    c.salu = 1; c.salub = 3; c.sht_en = 1; c.sr_en = ir[20];
                    c.rf_rw = !(ir[24] && !ir[23]);
                    if (ir[25]) c.se_en = 1;
                    else begin c.ssop = 1; c.srb = 3; c.ssab = 1; end
                end
            7:  begin c.se_en = 1; c.sise = 1; c.salub = 3; c.mar_en = 1;
                      c.alua = ir[23] ? 4'b0100 : 4'b0010; end
            8:  begin c.mfa = 1; c.rw_ram = 1; c.sma = 1; c.mdr_en = 1;
                      c.ds = ir[22] ? 2'b00 : 2'b10; end
            9:  begin c.alua = 4'b1101; c.rf_rw = 1; end
            10: begin c.srb = 2; c.ssop = 1; c.salub = 3; c.alua = 4'b1101; c.mdr_en = 1; end
            11: begin c.mfa = 1; c.ds = ir[22] ? 2'b00 : 2'b10; end
            12: begin c.srb = 1; c.ssop = 1; c.salub = 3; c.alua = 4'b1101; c.wra = 2; c.rf_rw = 1; end
            13: begin c.sra = 1; c.salub = 2; c.alua = 4'b0100; c.wra = 1; c.rf_rw = 1; end
            31: c.fault = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit cond_ok(logic [3:0] cc, logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            0: return z;            1: return !z;
            2: return c;            3: return !c;
            4: return n;            5: return !n;
            6: return v;            7: return !v;
            8: return c & !z;       9: return !c | z;
            10: return n == v;      11: return n != v;
            12: return !z & (n == v);
            13: return z | (n != v);
            14: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // MFC outside wait states is random noise that must be ignored.
    task automatic push(int st);
        q.push_back('{st, bit'($urandom_range(0, 1))});
    endtask

    task automatic add_wait(int st, int d, output bit timed_out);
        timed_out = (d >= MEM_TIMEOUT);
        for (int i = 0; i < (timed_out ? MEM_TIMEOUT : d); i++) q.push_back('{st, 1'b0});
        if (timed_out) push(31);
        else q.push_back('{st, 1'b1});
    endtask

    task automatic build(logic [31:0] ir, logic [3:0] fl, int fd, int md);
        bit to;
        q.delete();
        push(1); push(2);
        add_wait(3, fd, to);
        if (to) return;
        push(4); push(5);
        if (!cond_ok(ir[31:28], fl)) return;
        if (ir[27:26] == 2'b00) push(6);
        else if (ir[27:25] == 3'b010) begin
            push(7);
            if (ir[20]) begin
                add_wait(8, md, to);
                if (!to) push(9);
            end else begin
                push(10);
                add_wait(11, md, to);
            end
        end else if (ir[27:25] == 3'b101) begin
            if (ir[24]) push(12);
            push(13);
        end
    endtask

    task automatic check(string tag, int st, logic [31:0] ir);
        ctl_t e;
        e = exp_ctl(st, ir);
        checks++;
        assert (bus.STATE === 5'(st)) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, bus.STATE, st);
        end
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s ctl in state %0d: got %h expected %h", tag, st, got, e);
        end
    endtask

    // Entered with the DUT in FETCH1; leaves it in FETCH1 (or HALT on timeout).
    task automatic run(string tag, logic [31:0] ir, logic [3:0] fl, int fd, int md, int abort_at);
        bus.IR_Out = ir;
        bus.Flags  = fl;
        build(ir, fl, fd, md);
        foreach (q[i]) begin
            check(tag, q[i].st, ir);
            if (i == abort_at) begin
                CLR = 1'b1;
                tick();
                check({tag, "_clr"}, 0, ir);
                CLR = 1'b0;
                tick();
                return;
            end
            bus.MFC = q[i].mfc;
            tick();
        end
    endtask

    initial begin
        logic [31:0] ir;
        bus.IR_Out = 32'h0;
        bus.Flags  = 4'h0;
        bus.MFC    = 1'b0;

        CLR = 1'b1;
        tick(); check("rst0", 0, 32'h0);
        bus.MFC = 1'b1;
        tick(); check("rst1", 0, 32'h0);
        CLR = 1'b0;
        bus.MFC = 1'b0;
        tick();

        run("add_reg",  32'hE0821003, 4'h0, 0, 0, -1);
        run("eq_false", 32'h00821003, 4'h0, 2, 0, -1);
        run("eq_true",  32'h00821003, 4'h4, 1, 0, -1);
        run("cmp_imm",  32'hE3510005, 4'h0, 0, 0, -1);
        run("ldrb",     32'hE5D21004, 4'h0, 0, 3, -1);
        run("str_sub",  32'hE5021004, 4'h0, 1, 2, -1);
        run("bl",       32'hEB000002, 4'h0, 0, 0, -1);
        run("b",        32'hEA000010, 4'h0, 0, 0, -1);
        run("nop_cls",  32'hE7000000, 4'h0, 0, 0, -1);
        run("wd_edge",  32'hE0821003, 4'h0, MEM_TIMEOUT - 1, 0, -1);
        run("ld_edge",  32'hE5921004, 4'h0, 0, MEM_TIMEOUT - 1, -1);
        run("ld_abort", 32'hE5921004, 4'h0, 0, 5, 7);

        for (int n = 0; n < 150; n++) begin
            ir = $urandom;
            case ($urandom_range(0, 3))
                0: ir[27:26] = 2'b00;
                1: ir[27:25] = 3'b010;
                2: ir[27:25] = 3'b101;
                default: ir[27:25] = 3'(3 + 3 * $urandom_range(0, 1) + $urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 3) != 0) ir[31:28] = 4'hE;
            run("rand", ir, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), -1);
        end

        run("timeout", 32'hE0821003, 4'h0, MEM_TIMEOUT + 5, 0, -1);
        for (int k = 0; k < 3; k++) begin
            bus.MFC = 1'b1;
            check("halt_hold", 31, 32'hE0821003);
            tick();
        end
        CLR = 1'b1;
        tick(); check("halt_clr", 0, 32'hE0821003);
        CLR = 1'b0;
        tick();
        run("after_halt", 32'hE0821003, 4'h0, 0, 0, -1);
        run("st_timeout", 32'hE5821004, 4'h0, 0, MEM_TIMEOUT + 1, -1);
        check("st_halt", 31, 32'hE5821004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
